// File: rtl/joystick_scanner_6btn_if.sv
// Serial bus between the scanner and the external parallel-in shift-register
// chain that serves both DB9 ports.
//   joy_data   : serial data from the chain (chain -> scanner)
//   joy_clk    : shift clock to the chain
//   joy_load_n : parallel-load strobe to the chain, active low
//   joy_sel    : select line to both DB9 ports (pin 7)
// master = scanner side, slave = pad/shift-register side.
interface joystick_scanner_6btn_if;
  logic joy_data;
  logic joy_clk;
  logic joy_load_n;
  logic joy_sel;

  modport master (
    input  joy_data,
    output joy_clk,
    output joy_load_n,
    output joy_sel
  );

  modport slave (
    output joy_data,
    input  joy_clk,
    input  joy_load_n,
    input  joy_sel
  );
endinterface

// File: rtl/joystick_scanner_6btn.sv
// Two-port Genesis-style 6-button pad scanner. Each frame runs 8 scans with
// joy_sel alternating 1/0, then publishes both ports' buttons at once.
// A scan parallel-loads the chain and shifts out 16 bits
// (bits 0-7 port 1, bits 8-15 port 2; per port U,D,L,R,P6,P9,-,-).
//   clk         : system clock
//   reset_n     : asynchronous active-low reset
//   joy         : serial chain bus (master modport)
//   joy1_o      : port-1 buttons, active low, {M,X,Y,Z,S,A,C,B,R,L,D,U}
//   joy2_o      : port-2 buttons, same format
//   frame_done  : one-clk pulse when joy1_o/joy2_o update
module joystick_scanner_6btn #(
  parameter int CLKDIV       = 8,
  parameter int SETTLE_TICKS = 4,
  parameter int GAP_TICKS    = 12500
) (
  input  logic                   clk,
  input  logic                   reset_n,
  joystick_scanner_6btn_if.master joy,
  output logic [11:0]            joy1_o,
  output logic [11:0]            joy2_o,
  output logic                   frame_done
);
  localparam int GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam logic [7:0]       TICK_LAST   = 8'(CLKDIV - 1);
  localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE_TICKS - 1);
  localparam logic [GAP_W-1:0] GAP_LAST    = GAP_W'(GAP_TICKS - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_SETTLE, S_UPDATE} state_t;

  state_t           state_q;
  logic [7:0]       tick_cnt_q, tick_cnt_d;
  logic             tick;
  logic [GAP_W-1:0] gap_cnt_q;
  logic [7:0]       sub_cnt_q;
  logic [3:0]       bit_cnt_q;
  logic [2:0]       phase_q;
  logic [15:0]      sreg_q;
  logic [11:0]      cap1_q, cap2_q;
  logic             six1_q, six2_q;
  logic [11:0]      joy1_q, joy2_q;
  logic             frame_done_q, joy_clk_q, joy_load_n_q, joy_sel_q;

  // Fold one scanned port byte {-,-,P9,P6,R,L,D,U} into the capture word.
  function automatic logic [11:0] cap_upd(logic [11:0] cap, logic [7:0] b,
                                          logic [2:0] ph);
    logic [11:0] c;
    c = cap;
    case (ph)
      3'd0:    c[5:0]  = b[5:0];  // C,B,R,L,D,U
      3'd1:    c[7:6]  = b[5:4];  // S,A
      3'd6:    c[11:8] = b[3:0];  // M,X,Y,Z
      default: c = cap;
    endcase
    return c;
  endfunction

  // Pads without the 6-button signature report M,X,Y,Z released.
  function automatic logic [11:0] out_sel(logic [11:0] cap, logic six);
    return six ? cap : {4'hF, cap[7:0]};
  endfunction

  // Free-running tick divider.
  always_comb begin
    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? 8'd0 : tick_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) tick_cnt_q <= 8'd0;
    else          tick_cnt_q <= tick_cnt_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      gap_cnt_q    <= '0;
      sub_cnt_q    <= 8'd0;
      bit_cnt_q    <= 4'd0;
      phase_q      <= 3'd0;
      sreg_q       <= 16'hFFFF;
      cap1_q       <= 12'hFFF;
      cap2_q       <= 12'hFFF;
      six1_q       <= 1'b0;
      six2_q       <= 1'b0;
      joy1_q       <= 12'hFFF;
      joy2_q       <= 12'hFFF;
      frame_done_q <= 1'b0;
      joy_clk_q    <= 1'b0;
      joy_load_n_q <= 1'b1;
      joy_sel_q    <= 1'b1;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (tick) begin
          if (gap_cnt_q == GAP_LAST) begin
            gap_cnt_q    <= '0;
            sub_cnt_q    <= 8'd0;
            phase_q      <= 3'd0;
            joy_load_n_q <= 1'b0;
            state_q      <= S_LOAD;
          end else begin
            gap_cnt_q <= gap_cnt_q + GAP_W'(1);
          end
        end
        S_LOAD: if (tick) begin
          if (sub_cnt_q == 8'd1) begin
            joy_load_n_q <= 1'b1;
            bit_cnt_q    <= 4'd0;
            state_q      <= S_SHIFT;
          end else begin
            sub_cnt_q <= sub_cnt_q + 8'd1;
          end
        end
        S_SHIFT: if (tick) begin
          // joy_clk_q doubles as the low/high half-bit marker; data is
          // taken on the same edge that raises joy_clk, before the chain shifts.
          if (!joy_clk_q) begin
            joy_clk_q         <= 1'b1;
            sreg_q[bit_cnt_q] <= joy.joy_data;
          end else begin
            joy_clk_q <= 1'b0;
            if (bit_cnt_q == 4'd15) begin
              cap1_q    <= cap_upd(cap1_q, sreg_q[7:0], phase_q);
              cap2_q    <= cap_upd(cap2_q, sreg_q[15:8], phase_q);
              if (phase_q == 3'd5) begin
                six1_q <= (sreg_q[3:0] == 4'd0);
                six2_q <= (sreg_q[11:8] == 4'd0);
              end
              joy_sel_q <= ~joy_sel_q;
              sub_cnt_q <= 8'd0;
              state_q   <= S_SETTLE;
            end else begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
          end
        end
        S_SETTLE: if (tick) begin
          if (sub_cnt_q == SETTLE_LAST) begin
            sub_cnt_q <= 8'd0;
            if (phase_q == 3'd7) begin
              // Outputs and frame_done are registered together, so they are
              // valid during the single UPDATE cycle.
              phase_q      <= 3'd0;
              joy1_q       <= out_sel(cap1_q, six1_q);
              joy2_q       <= out_sel(cap2_q, six2_q);
              frame_done_q <= 1'b1;
              state_q      <= S_UPDATE;
            end else begin
              phase_q      <= phase_q + 3'd1;
              joy_load_n_q <= 1'b0;
              state_q      <= S_LOAD;
            end
          end else begin
            sub_cnt_q <= sub_cnt_q + 8'd1;
          end
        end
        S_UPDATE: state_q <= S_IDLE;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  assign joy.joy_clk    = joy_clk_q;
  assign joy.joy_load_n = joy_load_n_q;
  assign joy.joy_sel    = joy_sel_q;
  assign joy1_o         = joy1_q;
  assign joy2_o         = joy2_q;
  assign frame_done     = frame_done_q;
endmodule

// File: tb/tb_joystick_scanner_6btn.sv
module tb_joystick_scanner_6btn;
  localparam int CLKDIV     = 8;
  localparam int SETTLE     = 4;
  localparam int GAP        = 20;
  localparam int SCAN_TICKS = 2 + 32 + SETTLE;
  localparam int FRAME_CLKS = (GAP + 8 * SCAN_TICKS) * CLKDIV;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [11:0] joy1, joy2;
  logic        frame_done;

  joystick_scanner_6btn_if jif ();

  joystick_scanner_6btn #(
    .CLKDIV(CLKDIV), .SETTLE_TICKS(SETTLE), .GAP_TICKS(GAP)
  ) dut (
    .clk(clk), .reset_n(reset_n), .joy(jif),
    .joy1_o(joy1), .joy2_o(joy2), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // ---------------- pad + shift-register chain model ----------------
  // Pad type: 0 = none, 1 = 3-button, 2 = 6-button. Buttons active low,
  // {M,X,Y,Z,S,A,C,B,R,L,D,U}.
  int          cfg_t1 = 0, cfg_t2 = 0;
  logic [11:0] cfg_b1 = 12'hFFF, cfg_b2 = 12'hFFF;
  logic [15:0] sr = 16'hFFFF;
  int          ld_cnt = 0;

  function automatic logic [7:0] pad_byte(int t, logic [11:0] b, int ph);
    if (t == 0) return 8'hFF;
    if (ph % 2 == 0) begin
      if (t == 2 && ph == 6) return {2'b11, b[5], b[4], b[11], b[10], b[9], b[8]};
      return {2'b11, b[5], b[4], b[3], b[2], b[1], b[0]};
    end
    if (t == 2 && ph == 5) return {2'b11, b[7], b[6], 4'b0000};
    if (t == 2 && ph == 7) return {2'b11, b[7], b[6], 4'b1111};
    return {2'b11, b[7], b[6], 2'b00, b[1], b[0]};
  endfunction

  function automatic logic [11:0] model(int t, logic [11:0] b);
    if (t == 0) return 12'hFFF;
    if (t == 2) return b;
    return {4'hF, b[7:0]};
  endfunction

  assign jif.joy_data = sr[0];

  always @(negedge jif.joy_load_n or posedge jif.joy_clk or negedge reset_n) begin
    if (!reset_n) ld_cnt = 0;
    else if (!jif.joy_load_n) begin
      sr = {pad_byte(cfg_t2, cfg_b2, ld_cnt % 8), pad_byte(cfg_t1, cfg_b1, ld_cnt % 8)};
      ld_cnt++;
    end else sr = {1'b1, sr[15:1]};
  end

  // ---------------- bus timing monitor ----------------
  int   cyc, last_rise, scan_rises, rises, loads, togs, ld_start, last_fd;
  bit   period_bad, scan_bad, ldw_bad, fd_long, partial;
  logic p_jc, p_ld, p_sel, p_fd;
  logic [11:0] p_j1, p_j2;
  int   s_rises, s_loads, s_togs, s_spacing;
  bit   s_period_bad, s_scan_bad, s_ldw_bad;

  always @(negedge clk) begin
    if (!reset_n) begin
      cyc = 0; rises = 0; loads = 0; togs = 0; scan_rises = 0; last_fd = 0;
      last_rise = 0; ld_start = 0;
      period_bad = 0; scan_bad = 0; ldw_bad = 0;
    end else begin
      cyc++;
      if (jif.joy_clk && !p_jc) begin
        if (scan_rises > 0 && cyc - last_rise != 2 * CLKDIV) period_bad = 1;
        last_rise = cyc; scan_rises++; rises++;
      end
      if (!jif.joy_load_n && p_ld) begin
        if (scan_rises != 0 && scan_rises != 16) scan_bad = 1;
        scan_rises = 0; loads++; ld_start = cyc;
      end
      if (jif.joy_load_n && !p_ld && cyc - ld_start != 2 * CLKDIV) ldw_bad = 1;
      if (jif.joy_sel != p_sel) togs++;
      if ((joy1 != p_j1 || joy2 != p_j2) && !frame_done) partial = 1;
      if (frame_done) begin
        if (p_fd) fd_long = 1;
        if (scan_rises != 16) scan_bad = 1;
        s_rises = rises; s_loads = loads; s_togs = togs; s_spacing = cyc - last_fd;
        s_period_bad = period_bad; s_scan_bad = scan_bad; s_ldw_bad = ldw_bad;
        rises = 0; loads = 0; togs = 0; scan_rises = 0; last_fd = cyc;
        period_bad = 0; scan_bad = 0; ldw_bad = 0;
      end
    end
    p_jc = jif.joy_clk; p_ld = jif.joy_load_n; p_sel = jif.joy_sel; p_fd = frame_done;
    p_j1 = joy1; p_j2 = joy2;
  end

  // ---------------- checking ----------------
  int checks = 0, errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_frame(output bit ok, output int n);
    ok = 0;
    n  = 0;
    for (int k = 0; k < 3 * FRAME_CLKS; k++) begin
      @(negedge clk);
      n++;
      if (frame_done) begin ok = 1; break; end
    end
    #1;
  endtask

  typedef struct {
    int t1; logic [11:0] b1;
    int t2; logic [11:0] b2;
    logic [11:0] e1, e2;
  } vec_t;

  vec_t tbl [6];

  initial begin
    bit ok;
    int n;

    tbl[0] = '{0, 12'hFFF, 0, 12'hFFF, 12'hFFF, 12'hFFF};
    tbl[1] = '{1, 12'hFEE, 0, 12'hFFF, 12'hFEE, 12'hFFF};
    tbl[2] = '{0, 12'hFFF, 2, 12'h37F, 12'hFFF, 12'h37F};
    tbl[3] = '{2, 12'hFFF, 1, 12'h002, 12'hFFF, 12'hF02};
    tbl[4] = '{2, 12'h000, 2, 12'h5A5, 12'h000, 12'h5A5};
    tbl[5] = '{1, 12'h0F1, 2, 12'h800, 12'hFF1, 12'h800};

    cfg_t1 = tbl[0].t1; cfg_b1 = tbl[0].b1; cfg_t2 = tbl[0].t2; cfg_b2 = tbl[0].b2;
    reset_n = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_joy1", joy1, 12'hFFF);
    chk("rst_joy2", joy2, 12'hFFF);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_joy_clk", jif.joy_clk, 0);
    chk("rst_joy_load_n", jif.joy_load_n, 1);
    chk("rst_joy_sel", jif.joy_sel, 1);
    reset_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      cfg_t1 = tbl[i].t1; cfg_b1 = tbl[i].b1; cfg_t2 = tbl[i].t2; cfg_b2 = tbl[i].b2;
      wait_frame(ok, n);
      chk($sformatf("tbl%0d_frame_timeout", i), ok, 1);
      chk($sformatf("tbl%0d_joy1", i), joy1, tbl[i].e1);
      chk($sformatf("tbl%0d_joy2", i), joy2, tbl[i].e2);
      chk($sformatf("tbl%0d_clk_rises", i), s_rises, 128);
      chk($sformatf("tbl%0d_load_pulses", i), s_loads, 8);
      chk($sformatf("tbl%0d_sel_toggles", i), s_togs, 8);
      chk($sformatf("tbl%0d_clk_period_bad", i), s_period_bad, 0);
      chk($sformatf("tbl%0d_rises_per_scan_bad", i), s_scan_bad, 0);
      chk($sformatf("tbl%0d_load_width_bad", i), s_ldw_bad, 0);
      if (i > 0) chk($sformatf("tbl%0d_frame_spacing", i), s_spacing, FRAME_CLKS);
    end

    for (int i = 0; i < 8; i++) begin
      int t1, t2;
      logic [11:0] b1, b2;
      t1 = $urandom_range(0, 2); t2 = $urandom_range(0, 2);
      b1 = 12'($urandom); b2 = 12'($urandom);
      // A 3-button pad holding both U and D is indistinguishable from the
      // 6-button signature, so keep such combinations out of the stimulus.
      if (t1 == 1 && b1[1:0] == 2'b00) b1[0] = 1'b1;
      if (t2 == 1 && b2[1:0] == 2'b00) b2[0] = 1'b1;
      cfg_t1 = t1; cfg_b1 = b1; cfg_t2 = t2; cfg_b2 = b2;
      wait_frame(ok, n);
      chk($sformatf("rnd%0d_frame_timeout", i), ok, 1);
      chk($sformatf("rnd%0d_joy1", i), joy1, model(t1, b1));
      chk($sformatf("rnd%0d_joy2", i), joy2, model(t2, b2));
    end

    // Reset in the middle of phase 4.
    cfg_t1 = 2; cfg_b1 = 12'h000; cfg_t2 = 2; cfg_b2 = 12'h000;
    wait_frame(ok, n);
    chk("pre_rst_frame_timeout", ok, 1);
    chk("pre_rst_joy1", joy1, 12'h000);
    chk("pre_rst_joy2", joy2, 12'h000);
    cfg_t1 = 1; cfg_b1 = 12'hFFE; cfg_t2 = 0; cfg_b2 = 12'hFFF;
    ok = 0;
    for (int k = 0; k < 2 * FRAME_CLKS; k++) begin
      @(negedge clk);
      if (ld_cnt % 8 == 5) begin ok = 1; break; end
    end
    chk("phase4_wait_timeout", ok, 1);
    repeat (40) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrst_joy1", joy1, 12'hFFF);
    chk("midrst_joy2", joy2, 12'hFFF);
    chk("midrst_joy_sel", jif.joy_sel, 1);
    chk("midrst_joy_load_n", jif.joy_load_n, 1);
    chk("midrst_joy_clk", jif.joy_clk, 0);
    chk("midrst_frame_done", frame_done, 0);
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    wait_frame(ok, n);
    chk("post_rst_frame_timeout", ok, 1);
    chk("post_rst_latency", n, FRAME_CLKS);
    chk("post_rst_joy1", joy1, 12'hFFE);
    chk("post_rst_joy2", joy2, 12'hFFF);
    chk("post_rst_load_pulses", s_loads, 8);

    repeat (100) @(negedge clk);
    chk("hold_joy1", joy1, 12'hFFE);
    chk("frame_done_wide", fd_long, 0);
    chk("partial_output_change", partial, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/joystick_scanner_6btn.md
JOYSTICK_SCANNER_6BTN -- requirements
Module: joystick_scanner_6btn

Interface
REQ-001 SHALL provide parameter CLKDIV, default 8: clk cycles per half-period of joy_clk, i.e. one "tick"; legal range 2..255.
REQ-002 SHALL provide parameter SETTLE_TICKS, default 4: ticks waited after every joy_sel change before the next scan.
REQ-003 SHALL provide parameter GAP_TICKS, default 12500: idle ticks between frames, 2 ms at 50 MHz, meeting the >1.5 ms 6-button pad timeout.
REQ-004 clk  input  1  system clock, 50 MHz nominal.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 joy_data  input  1  serial data from the external parallel-in shift-register chain.
REQ-007 joy_clk  output  1  shift clock to the chain.
REQ-008 joy_load_n  output  1  parallel-load strobe to the chain, active low.
REQ-009 joy_sel  output  1  select line to both DB9 ports (pin 7).
REQ-010 joy1_o  output  12  port-1 buttons, active low, {M,X,Y,Z,S,A,C,B,R,L,D,U} = bits 11..0.
REQ-011 joy2_o  output  12  port-2 buttons, same format.
REQ-012 frame_done  output  1  one-clk pulse when joy1_o/joy2_o update.

Function
REQ-013 SHALL generate a tick enable every CLKDIV clk cycles; all state changes below occur only on tick cycles.
REQ-014 Scan: LOAD drives joy_load_n low for 2 ticks with joy_clk low. SHIFT then samples 16 bits, each taking a low tick and a high tick, and samples joy_data in the clk cycle where joy_clk goes 0->1.
REQ-015 Serial order SHALL be: bits 0-7 port 1, bits 8-15 port 2; within each port U, D, L, R, P6, P9, unused, unused.
REQ-016 A frame SHALL contain 8 scans, phases 0..7. joy_sel is 1 in even phases and 0 in odd phases. joy_sel toggles after each scan and is followed by SETTLE, which waits SETTLE_TICKS ticks.
REQ-017 State sequence: IDLE -> LOAD -> SHIFT -> SETTLE -> LOAD (phase+1). After the SETTLE that follows phase 7, the block SHALL go to UPDATE for 1 clk, then back to IDLE.
REQ-018 IDLE waits GAP_TICKS ticks with joy_sel=1, joy_clk=0, joy_load_n=1.
REQ-019 Per-port decode:
- Phase 0 supplies U, D, L, R, B=P6, C=P9.
- Phase 1 supplies A=P6, S=P9.
- Phase 5 with U, D, L, R all 0 flags a 6-button pad.
- Phase 6 supplies Z=U, Y=D, X=L, M=R.
REQ-020 If the 6-button flag is clear, the port SHALL report M, X, Y, Z = 1111; all other bits are still reported.
REQ-021 UPDATE SHALL load joy1_o and joy2_o together from the frame's captured values and pulse frame_done for exactly that clk; outputs hold between updates.
REQ-022 Capture registers SHALL be internal; no partial-frame value may appear on joy1_o or joy2_o.
REQ-023 The tick counter and phase counter SHALL wrap to 0 cleanly; the phase counter is 3 bits, and the bit counter is 4 bits covering 0..15.
REQ-024 joy_clk, joy_load_n and joy_sel SHALL be registered outputs, free of glitches.

Reset
REQ-025 While reset_n=0, outputs SHALL be: joy1_o=joy2_o=12'hFFF, frame_done=0, joy_clk=0, joy_load_n=1, joy_sel=1.
REQ-026 Reset state SHALL be IDLE with tick, bit, phase and gap counters at 0 and 6-button flags cleared.
REQ-027 Reset asserted mid-frame SHALL discard the partial frame; the first frame_done after release SHALL come only after a full GAP plus 8 scans.

Verification
REQ-028 Pad model, all lines high (no pads) -> after the first frame, frame_done pulses once, joy1_o=joy2_o=12'hFFF.
REQ-029 Port 1 3-button pad with Up+B pressed: phase 0 bits U=0, P6=0; phase 1 L=R=0; phase 5 L=R=0 only -> joy1_o=12'hFEE, joy2_o=12'hFFF.
REQ-030 Port 2 6-button pad with Start+Mode+X pressed: phase 1 P9=0; phase 5 U, D, L, R = 0; phase 6 L=0, R=0 -> joy2_o=12'h37F.
REQ-031 Timing, CLKDIV=8: joy_clk period = 16 clk; 16 rising edges per scan; 8 joy_load_n pulses per frame; joy_sel toggles 8 times per frame; frame spacing ≥ GAP_TICKS*8 clk.
REQ-032 reset_n pulsed low during phase 4 -> outputs return to 12'hFFF and joy_sel=1 asynchronously. The next frame restarts at phase 0 after a full gap, with no stale X/Y/Z/M data.
